// File: rtl/universal_counter_n.sv
// universal_counter_n: parametrised synchronous modulo-N up/down counter with
// 74LS161-style ENP/ENT enables, combinational ripple carry (RCO) for
// cascading, parallel load with clamping to MODULUS-1, and a registered
// one-cycle WRAP pulse that follows every wrapping edge.
module universal_counter_n #(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 16,
  parameter longint unsigned RST_VAL = 0
) (
  input  logic             CLK,
  input  logic             CLR_n,
  input  logic             LOAD_n,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             UP_DN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             WRAP
);

  // Elaboration-time parameter checks: an illegal combination stops the build.
  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("universal_counter_n: WIDTH must be in 1..32");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
      $error("universal_counter_n: MODULUS must be in 2..2**WIDTH");
    end
    if (RST_VAL >= MODULUS) begin : g_bad_rst_val
      $error("universal_counter_n: RST_VAL must be below MODULUS");
    end
  endgenerate

  // Largest legal count value and the reset value at counter width.
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic             wrap_reg;
  logic             wrap_next;
  logic             count_en;
  logic             at_top;
  logic             at_bottom;

  assign count_en  = ENP & ENT;
  assign at_top    = (q_reg == MAX_Q);
  assign at_bottom = (q_reg == '0);

  // Next-state selection: load beats counting; wrap is flagged only on the
  // edge that moves across the modulus boundary in the current direction.
  always_comb begin
    q_next    = q_reg;
    wrap_next = 1'b0;
    if (!LOAD_n) begin
      q_next = (D > MAX_Q) ? MAX_Q : D;
    end else if (count_en) begin
      if (UP_DN) begin
        if (at_top) begin
          q_next    = '0;
          wrap_next = 1'b1;
        end else begin
          q_next = q_reg + WIDTH'(1);
        end
      end else begin
        if (at_bottom) begin
          q_next    = MAX_Q;
          wrap_next = 1'b1;
        end else begin
          q_next = q_reg - WIDTH'(1);
        end
      end
    end
  end

  // State register; the synchronous clear overrides load, count and any
  // wrap pulse that would otherwise have been produced on this edge.
  always_ff @(posedge CLK) begin
    if (!CLR_n) begin
      q_reg    <= RST_Q;
      wrap_reg <= 1'b0;
    end else begin
      q_reg    <= q_next;
      wrap_reg <= wrap_next;
    end
  end

  // Ripple carry: terminal value depends on direction, gated by ENT only,
  // so a chain of stages sees the carry with no added latency.
  always_comb begin
    RCO = ENT & (UP_DN ? at_top : at_bottom);
  end

  assign Q    = q_reg;
  assign WRAP = wrap_reg;

endmodule

// File: tb/tb_universal_counter_n.sv
// tb_universal_counter_n: drives a 4-bit binary counter, a decade counter,
// a 1-bit modulo-2 counter and a two-stage 8-bit cascade, comparing every
// output against an arithmetic reference model after each clock edge.
module tb_universal_counter_n;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Shared controls for the single-stage instances
  logic       clr_n, load_n, enp, ent, up_dn;
  logic [3:0] d;
  // Cascade controls
  logic       c_clr_n, c_load_n, c_enp, c_ent, c_up;
  logic [7:0] c_d;

  logic [3:0] q16, q10, cq0, cq1;
  logic [0:0] q2;
  logic       rco16, rco10, rco2, wrap16, wrap10, wrap2;
  logic       crco0, crco1, cwrap0, cwrap1;

  universal_counter_n #(.WIDTH(4), .MODULUS(16), .RST_VAL(0)) u16 (
    .CLK(CLK), .CLR_n(clr_n), .LOAD_n(load_n), .ENP(enp), .ENT(ent),
    .UP_DN(up_dn), .D(d), .Q(q16), .RCO(rco16), .WRAP(wrap16));

  universal_counter_n #(.WIDTH(4), .MODULUS(10), .RST_VAL(7)) u10 (
    .CLK(CLK), .CLR_n(clr_n), .LOAD_n(load_n), .ENP(enp), .ENT(ent),
    .UP_DN(up_dn), .D(d), .Q(q10), .RCO(rco10), .WRAP(wrap10));

  universal_counter_n #(.WIDTH(1), .MODULUS(2), .RST_VAL(1)) u2 (
    .CLK(CLK), .CLR_n(clr_n), .LOAD_n(load_n), .ENP(enp), .ENT(ent),
    .UP_DN(up_dn), .D(d[0:0]), .Q(q2), .RCO(rco2), .WRAP(wrap2));

  universal_counter_n #(.WIDTH(4), .MODULUS(16), .RST_VAL(0)) uc0 (
    .CLK(CLK), .CLR_n(c_clr_n), .LOAD_n(c_load_n), .ENP(c_enp), .ENT(c_ent),
    .UP_DN(c_up), .D(c_d[3:0]), .Q(cq0), .RCO(crco0), .WRAP(cwrap0));

  universal_counter_n #(.WIDTH(4), .MODULUS(16), .RST_VAL(0)) uc1 (
    .CLK(CLK), .CLR_n(c_clr_n), .LOAD_n(c_load_n), .ENP(c_enp), .ENT(crco0),
    .UP_DN(c_up), .D(c_d[7:4]), .Q(cq1), .RCO(crco1), .WRAP(cwrap1));

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int m16, m10, m2, mc;
  bit w16, w10, w2, wc0, wc1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One counter of modulus 'md' viewed as modular arithmetic on an integer.
  task automatic mstep(input int md, input int rv, input int q, input int dv,
                       output int nq, output bit nw);
    nq = q;
    nw = 1'b0;
    if (!clr_n) begin
      nq = rv;
    end else if (!load_n) begin
      nq = (dv > md - 1) ? md - 1 : dv;
    end else if (enp && ent) begin
      if (up_dn) begin
        nq = (q + 1) % md;
        nw = (nq == 0);
      end else begin
        nq = (q + md - 1) % md;
        nw = (nq == md - 1);
      end
    end
  endtask

  // The cascade behaves as a single 8-bit counter; nibble wraps come from the
  // arithmetic value.
  task automatic cstep();
    int nv;
    wc0 = 1'b0;
    wc1 = 1'b0;
    if (!c_clr_n) begin
      mc = 0;
    end else if (!c_load_n) begin
      mc = int'(c_d);
    end else if (c_enp && c_ent) begin
      nv  = c_up ? (mc + 1) % 256 : (mc + 255) % 256;
      wc0 = c_up ? ((nv % 16) == 0) : ((nv % 16) == 15);
      wc1 = c_up ? (nv == 0) : (nv == 255);
      mc  = nv;
    end
  endtask

  function automatic bit exp_rco(input int q, input int md, input bit e, input bit u);
    return e && (q == (u ? md - 1 : 0));
  endfunction

  task automatic check_rco();
    chk("rco16", 32'(rco16), 32'(exp_rco(m16, 16, ent, up_dn)));
    chk("rco10", 32'(rco10), 32'(exp_rco(m10, 10, ent, up_dn)));
    chk("rco2",  32'(rco2),  32'(exp_rco(m2, 2, ent, up_dn)));
    chk("crco0", 32'(crco0), 32'(exp_rco(mc % 16, 16, c_ent, c_up)));
    chk("crco1", 32'(crco1), 32'(exp_rco(mc, 256, c_ent, c_up)));
  endtask

  // Check combinational carry with new inputs, clock once, update the model,
  // then check every registered output.
  task automatic tick();
    int n16, n10, n2;
    #1;
    check_rco();
    @(posedge CLK);
    mstep(16, 0, m16, int'(d), n16, w16);
    mstep(10, 7, m10, int'(d), n10, w10);
    mstep(2, 1, m2, int'(d[0]), n2, w2);
    m16 = n16; m10 = n10; m2 = n2;
    cstep();
    #1;
    chk("q16", 32'(q16), 32'(m16));
    chk("wrap16", 32'(wrap16), 32'(w16));
    chk("q10", 32'(q10), 32'(m10));
    chk("wrap10", 32'(wrap10), 32'(w10));
    chk("q2", 32'(q2), 32'(m2));
    chk("wrap2", 32'(wrap2), 32'(w2));
    chk("cq", 32'({cq1, cq0}), 32'(mc));
    chk("cwrap0", 32'(cwrap0), 32'(wc0));
    chk("cwrap1", 32'(cwrap1), 32'(wc1));
    check_rco();
  endtask

  initial begin
    m16 = 0; m10 = 0; m2 = 0; mc = 0;
    clr_n = 1'b0; load_n = 1'b1; enp = 1'b0; ent = 1'b0; up_dn = 1'b1; d = 4'd0;
    c_clr_n = 1'b0; c_load_n = 1'b1; c_enp = 1'b0; c_ent = 1'b0; c_up = 1'b1; c_d = 8'd0;

    // Reset across an edge
    tick();
    chk("rst_q16", 32'(q16), 32'd0);
    chk("rst_q10", 32'(q10), 32'd7);
    chk("rst_wrap16", 32'(wrap16), 32'd0);
    clr_n = 1'b1; c_clr_n = 1'b1;

    // Load 2, then 13 up counts to 15, then wrap
    load_n = 1'b0; d = 4'd2;
    tick();
    chk("load2", 32'(q16), 32'd2);
    load_n = 1'b1; enp = 1'b1; ent = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    chk("top15", 32'(q16), 32'd15);
    chk("top_rco", 32'(rco16), 32'd1);
    tick();
    chk("wrap_q", 32'(q16), 32'd0);
    chk("wrap_pulse", 32'(wrap16), 32'd1);
    tick();
    chk("wrap_once", 32'(wrap16), 32'd0);

    // Decade up count from 0 through two wraps, then clamped load
    load_n = 1'b0; d = 4'd0;
    tick();
    load_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    load_n = 1'b0; d = 4'd12;
    tick();
    chk("clamp10", 32'(q10), 32'd9);

    // Down count from 1 in decade mode: 1,0,9,8
    d = 4'd1;
    tick();
    load_n = 1'b1; up_dn = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("down8", 32'(q10), 32'd8);

    // Enable gating at 15 in up mode
    load_n = 1'b0; d = 4'd15; up_dn = 1'b1;
    tick();
    load_n = 1'b1; enp = 1'b0; ent = 1'b1;
    tick();
    chk("hold15", 32'(q16), 32'd15);
    ent = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    // Clear and load together on a terminal value, then a plain load
    enp = 1'b1; ent = 1'b1; clr_n = 1'b0; load_n = 1'b0;
    tick();
    chk("clr_pri", 32'(q16), 32'd0);
    clr_n = 1'b1; d = 4'd5;
    tick();
    chk("load5", 32'(q16), 32'd5);
    load_n = 1'b1;

    // Cascade: 255 up counts from 0, then the joint wrap
    c_enp = 1'b1; c_ent = 1'b1; c_up = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    chk("casc_ff", 32'({cq1, cq0}), 32'hFF);
    tick();
    chk("casc_wrap", 32'({cwrap1, cwrap0}), 32'd3);

    // Randomised mixed operation on every instance
    for (int i = 0; i < 400; i++) begin
      clr_n  = ($urandom_range(0, 19) != 0);
      load_n = ($urandom_range(0, 7) != 0);
      enp    = ($urandom_range(0, 4) != 0);
      ent    = ($urandom_range(0, 4) != 0);
      up_dn  = 1'($urandom_range(0, 1));
      d      = 4'($urandom_range(0, 15));
      c_clr_n  = ($urandom_range(0, 39) != 0);
      c_load_n = ($urandom_range(0, 15) != 0);
      c_enp    = ($urandom_range(0, 5) != 0);
      c_ent    = ($urandom_range(0, 5) != 0);
      c_up     = ($urandom_range(0, 3) != 0);
      c_d      = 8'($urandom_range(0, 255));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
